uart_rx_port: RTL and testbench
===============================

Name: uart_rx_port

Overview:
- Memory-mapped serial input peripheral for the 8-bit RISC-V core.
- Receives 8N1 bytes on UART_RXD and buffers them in a small FIFO.
- The core reads data and status through the load path, alongside the parallel input mux on the ResultSrc=1 path.
- It is the receiving end of the board serial link; the existing parallel output port is the core's write-side counterpart.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, 2..16.
DATA_ADDR, 8'hF8, load address returning the FIFO head byte and popping it.
STATUS_ADDR, 8'hF9, load address returning the status byte.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous active-low reset.
rxd  in  1  serial line, idle high, asynchronous to clk.
Address  in  8  core ALU result (load address).
RdEn  in  1  one-cycle read strobe, qualified by Address.
RegData  out  8  combinational read data for the current Address.
RxValid  out  1  FIFO not empty.
RxErr  out  1  OR of the sticky error flags.

Behaviour:
- Reset (rst=0, async):
  - FSM returns to IDLE; FIFO is emptied.
  - Sticky flags clear; synchronizer flops set to 1.
  - RxValid=0, RxErr=0.
  - RegData follows Address: 8'h00 for DATA_ADDR while empty, 8'h00 for STATUS_ADDR.
- Input sync: rxd passes through a 2-flop synchronizer (rxs). All sampling uses rxs.
- FSM:
  - IDLE: on rxs=0 -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. rxs=0 -> DATA; rxs=1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into the shift register; then -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rxs=1 -> push the byte; go to IDLE.
    - rxs=0 -> set frame_err and discard the byte; go to BREAK.
  - BREAK: stay until rxs=1, then go to IDLE. A held-low line produces no further bytes or errors.
- FIFO:
  - Push occurs on the clk edge that samples a valid stop bit; RxValid rises the next cycle.
  - Pop happens when RdEn=1, Address==DATA_ADDR and the FIFO is non-empty.
  - Pop on empty is ignored; RegData reads 8'h00.
  - Push while full (and no pop in the same cycle): byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: RegData shows 8'h00 that cycle, and the byte is retained.
  - Pointers wrap modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits.
- Reads:
  - Address==DATA_ADDR: RegData = FIFO head.
  - Address==STATUS_ADDR: RegData = {4'b0, parity_err, frame_err, overrun, RxValid}.
  - Any other Address: RegData = 8'h00.
  - RdEn with Address==STATUS_ADDR clears overrun, frame_err and parity_err on that edge. An error event in the same cycle wins, so the flag stays set.
- RxErr = overrun | frame_err | parity_err.
- Reset mid-frame aborts the frame; no partial byte is pushed.
- Baud counter range is 0..CLKS_PER_BIT-1 and reloads at each sample point.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples 1 bit after CLKS_PER_BIT cycles.
  - Even-parity mismatch sets parity_err (status bit 3) and discards the byte.
  - The stop bit is still checked.
- Undefined: 8N1, no PARITY state, and status bit 3 is constant 0.

Test Plan (sim with CLKS_PER_BIT=8, FIFO_DEPTH=4):
- Reset, then send 0x5A 8N1 -> RxValid=1 one cycle after the stop sample. Read DATA_ADDR -> RegData=0x5A; next cycle RxValid=0, status reads 0x00.
- Send 0x01,0x02,0x03,0x04,0x05 with no reads -> status=0x03 (overrun+valid). Reads return 01,02,03,04 then 00; 0x05 is lost. Status read clears it to 0x00.
- Send 0xA5 with stop bit forced 0, then hold the line low for 40 cycles, then release -> frame_err set, FIFO empty, no additional bytes. Status=0x04, RxErr=1.
- 2-cycle low pulse on the idle line -> START rejects it; FIFO empty, status 0x00.
- FIFO full with 4 bytes; pop on the same edge as the 5th byte's stop sample -> no overrun; FIFO holds bytes 2..5 in order.
- Assert rst mid-byte (after 4 data bits), release, send 0x3C -> only 0x3C is read. With UART_RX_PARITY_EN, send 0x3C with a wrong parity bit -> status bit 3 set and FIFO empty.

Source files
------------

// File: rtl/uart_rx_port.sv
// uart_rx_port: 8N1 serial receiver with a small read FIFO, mapped onto the core load path.
// Define UART_RX_PARITY_EN to receive 8E1 frames (parity checked ahead of the stop bit).
module uart_rx_port #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] DATA_ADDR    = 8'hF8,
    parameter logic [7:0] STATUS_ADDR  = 8'hF9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [7:0] Address,
    input  logic       RdEn,
    output logic [7:0] RegData,
    output logic       RxValid,
    output logic       RxErr
);
    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge
    // S_START  | half-bit wait, then confirm start bit (else glitch)
    // S_DATA   | eight data samples, LSB first
    // S_PARITY | even-parity sample (8E1 build only)
    // S_STOP   | stop-bit sample: push byte or flag framing error
    // S_BRK    | line held low after a framing error, wait for idle

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BRK
    } state_t;

    state_t              state;
    logic [1:0]          sync_q;
    logic                rxs;
    logic [BAUD_W-1:0]   baud_cnt;
    logic                baud_tc;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                stop_tc;
    logic                push_evt;
    logic                frame_evt;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                pop;
    logic                do_push;
    logic                ovr_evt;
    logic                clr_flags;
    logic                overrun;
    logic                frame_err;
    logic                parity_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end
    assign rxs = sync_q[1];

    assign baud_tc = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            // Sampling states share one reload-on-terminal-count baud timer.
            if (state != S_IDLE && state != S_BRK) begin
                baud_cnt <= baud_tc ? BIT_LAST : baud_cnt - BAUD_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state    <= S_START;
                        baud_cnt <= HALF_LAST;
                        bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (baud_tc) state <= rxs ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (baud_tc) begin
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= S_PARITY;
`else
                        if (bit_cnt == 3'd7) state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tc) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (baud_tc) state <= rxs ? S_IDLE : S_BRK;
                end
                S_BRK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stop_tc   = (state == S_STOP) && baud_tc;
    assign frame_evt = stop_tc && !rxs;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_evt;

    assign par_evt  = (state == S_PARITY) && baud_tc && (rxs != ^shreg);
    assign push_evt = stop_tc && rxs && !par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_IDLE) par_bad <= 1'b0;
            else if (par_evt)    par_bad <= 1'b1;
            parity_err <= par_evt | (parity_err & ~clr_flags);
        end
    end
`else
    assign push_evt   = stop_tc && rxs;
    assign parity_err = 1'b0;
`endif

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign RxValid   = (count != '0);
    assign pop       = RdEn && (Address == DATA_ADDR) && RxValid;
    assign clr_flags = RdEn && (Address == STATUS_ADDR);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push_evt && (!full || pop);
    assign ovr_evt   = push_evt && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overrun   <= ovr_evt   | (overrun   & ~clr_flags);
            frame_err <= frame_evt | (frame_err & ~clr_flags);
        end
    end

    assign RxErr = overrun | frame_err | parity_err;

    always_comb begin
        RegData = 8'h00;
        if (Address == DATA_ADDR) begin
            if (RxValid) RegData = mem[rd_ptr];
        end else if (Address == STATUS_ADDR) begin
            RegData = {4'b0000, parity_err, frame_err, overrun, RxValid};
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: directed frames plus randomized traffic, checked every cycle
// against a queue-based receiver model. Honours UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx_port;
    localparam int         C  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] DA = 8'hF8;
    localparam logic [7:0] SA = 8'hF9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       RdEn = 1'b0;
    logic [7:0] Address = 8'h00;
    logic [7:0] RegData;
    logic       RxValid;
    logic       RxErr;

    uart_rx_port #(
        .CLKS_PER_BIT(C), .FIFO_DEPTH(D), .DATA_ADDR(DA), .STATUS_ADDR(SA)
    ) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .Address(Address), .RdEn(RdEn),
        .RegData(RegData), .RxValid(RxValid), .RxErr(RxErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit rnd_rd = 1'b0;

    // kind: 0 = byte arrives, 1 = framing error, 2 = parity error
    typedef struct {
        int         edge_no;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ovr, m_ferr, m_perr;
    ev_t        ev;
    bit         m_pop, m_clr;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_regdata();
        if (Address == DA) return (mq.size() > 0) ? mq[0] : 8'h00;
        if (Address == SA) return {4'b0000, m_perr, m_ferr, m_ovr, mq.size() > 0};
        return 8'h00;
    endfunction

    // Receiver model: frame outcomes are scheduled by the sender at the stop-sample edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            evq.delete();
            m_ovr = 0; m_ferr = 0; m_perr = 0;
        end else begin
            cyc++;
            m_pop = RdEn && (Address == DA) && (mq.size() > 0);
            m_clr = RdEn && (Address == SA);
            if (m_clr) begin m_ovr = 0; m_ferr = 0; m_perr = 0; end
            if (m_pop) void'(mq.pop_front());
            while (evq.size() > 0 && evq[0].edge_no <= cyc) begin
                ev = evq.pop_front();
                case (ev.kind)
                    0: if (mq.size() == D) m_ovr = 1; else mq.push_back(ev.data);
                    1: m_ferr = 1;
                    default: m_perr = 1;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        #1;
        check("regdata", RegData, m_regdata());
        check("rxvalid", {7'b0, RxValid}, {7'b0, mq.size() > 0});
        check("rxerr", {7'b0, RxErr}, {7'b0, m_ovr | m_ferr | m_perr});
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_bit = 1, input bit bad_par = 0,
                              input int abort_bits = 0, input int low_hold = 0,
                              input bit pop_at_stop = 0, input int gap = 2);
        logic [10:0] bits;
        int nb, p0, s_edge;
`ifdef UART_RX_PARITY_EN
        nb   = 11;
        bits = {stop_bit, (^b) ^ bad_par, b, 1'b0};
`else
        nb   = 10;
        bits = {1'b0, stop_bit, b, 1'b0};
`endif
        p0 = 0; s_edge = 0;
        for (int i = 0; i < nb * C; i++) begin
            @(negedge clk);
            if (i == 0) begin
                p0 = cyc;
                // 2-flop sync + idle detect, half bit, then one bit time per remaining bit
                s_edge = p0 + 3 + C / 2 + (nb - 1) * C;
`ifdef UART_RX_PARITY_EN
                if (bad_par) evq.push_back('{s_edge - C, 2, b});
`endif
                if (!stop_bit)     evq.push_back('{s_edge, 1, b});
                else if (!bad_par) evq.push_back('{s_edge, 0, b});
            end
            if (abort_bits != 0 && i == abort_bits * C) begin
                rst = 1'b0; rxd = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            rxd = bits[i / C];
            if (pop_at_stop) begin
                if (cyc == s_edge - 1) begin Address = DA; RdEn = 1'b1; end
                else if (cyc == s_edge) RdEn = 1'b0;
            end
        end
        repeat (low_hold) @(negedge clk);
        @(negedge clk);
        rxd = 1'b1;
        if (pop_at_stop) RdEn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [7:0] e, input string nm);
        @(negedge clk);
        Address = a; RdEn = 1'b1;
        #1 check(nm, RegData, e);
        @(negedge clk);
        RdEn = 1'b0; Address = 8'h00;
    endtask

    int r;
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_rd) begin
                r = int'($urandom_range(0, 99));
                RdEn = (r < 4);
                if (r < 2 || r >= 60)      Address = DA;
                else if (r < 3 || r >= 30) Address = SA;
                else                       Address = 8'($urandom_range(0, 255));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    logic [7:0] rb;
    bit         rs, rp;
    initial begin
        repeat (3) @(negedge clk);
        Address = DA;
        #1 check("rst_data", RegData, 8'h00);
        Address = SA;
        #1 check("rst_status", RegData, 8'h00);
        check("rst_valid", {7'b0, RxValid}, 8'h00);
        check("rst_err", {7'b0, RxErr}, 8'h00);
        @(negedge clk);
        rst = 1'b1; Address = 8'h00;
        repeat (3) @(negedge clk);

        send_frame(8'h5A);
        #1 check("t1_valid", {7'b0, RxValid}, 8'h01);
        rd_check(DA, 8'h5A, "t1_data");
        #1 check("t1_valid_after", {7'b0, RxValid}, 8'h00);
        rd_check(SA, 8'h00, "t1_status");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rd_check(SA, 8'h03, "t2_status_ovr");
        for (int i = 1; i <= 4; i++) rd_check(DA, 8'(i), "t2_data");
        rd_check(DA, 8'h00, "t2_empty");
        rd_check(SA, 8'h00, "t2_status_clr");

        send_frame(8'hA5, 0, 0, 0, 40, 0, C + 2);
        #1 check("t3_rxerr", {7'b0, RxErr}, 8'h01);
        rd_check(SA, 8'h04, "t3_status_ferr");
        rd_check(SA, 8'h00, "t3_status_clr");

        @(negedge clk); rxd = 1'b0;
        repeat (2) @(negedge clk); rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd_check(SA, 8'h00, "t4_glitch");

        send_frame(8'h11, 1, 0, 0, 0, 0, 0);
        send_frame(8'h22, 1, 0, 0, 0, 0, 0);
        send_frame(8'h33, 1, 0, 0, 0, 0, 0);
        send_frame(8'h44, 1, 0, 0, 0, 0, 0);
        send_frame(8'h55, 1, 0, 0, 0, 1, 2);
        rd_check(SA, 8'h01, "t5_no_ovr");
        rd_check(DA, 8'h22, "t5_b2");
        rd_check(DA, 8'h33, "t5_b3");
        rd_check(DA, 8'h44, "t5_b4");
        rd_check(DA, 8'h55, "t5_b5");
        rd_check(SA, 8'h00, "t5_status");

        send_frame(8'hC3, 1, 0, 5);
        send_frame(8'h3C);
        rd_check(DA, 8'h3C, "t6_data");
        rd_check(DA, 8'h00, "t6_empty");
`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1, 1);
        rd_check(SA, 8'h08, "t6_parity");
        rd_check(SA, 8'h00, "t6_parity_clr");
`endif

        rnd_rd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 7) != 0);
            rp = 1'b0;
`ifdef UART_RX_PARITY_EN
            rp = ($urandom_range(0, 7) == 0);
`endif
            send_frame(rb, rs, rp, 0, 0, 0, rs ? int'($urandom_range(0, 5)) : C + 2);
        end
        rnd_rd = 1'b0;
        @(negedge clk);
        RdEn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i <= D; i++) begin
            @(negedge clk); Address = DA; RdEn = 1'b1;
        end
        @(negedge clk); Address = SA; RdEn = 1'b1;
        @(negedge clk); RdEn = 1'b0; Address = 8'h00;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
